fuel_dispense_meter: RTL
========================

// Module: fuel_dispense_meter
// PURPOSE
//   Downstream of the gas pump Moore controller. Consumes its fuel_out level as fuelEnable.
//   Meters dispensed volume in whole units and accumulates the transaction amount (volume x unit price).
//   Requests a stop when a preset volume is reached.
//   Runs a per-transaction FSM that the display/billing logic reads.
// PARAMETERS
//   TICKS_PER_UNIT  4   clock cycles with fuelEnable=1 per dispensed volume unit (>=2)
//   VOL_W           12  volume counter width
//   PRICE_W         8   unit price width
//   AMT_W           20  amount width; must be >= VOL_W+PRICE_W (no amount overflow possible)
// PORTS
//   clk           in   1        single clock, all state updates on rising edge
//   reset         in   1        asynchronous, active-high; clears all state immediately
//   fuelEnable    in   1        fuel_out of pump controller; 1 = fuel flowing this cycle
//   txnStart      in   1        1-cycle pulse: begin new transaction (latch price/preset, clear totals)
//   txnEnd        in   1        1-cycle pulse: customer finished (nozzle hung up)
//   presetVol     in   VOL_W    volume limit, sampled on accepted txnStart; 0 = no limit
//   unitPrice     in   PRICE_W  price per unit, sampled on accepted txnStart
//   volume        out  VOL_W    dispensed whole units this transaction
//   amount        out  AMT_W    accumulated price this transaction
//   limitReached  out  1        sticky: preset hit or volume saturated; stop request to controller
//   txnDone       out  1        1 while FSM in DONE
//   State_out     out  2        FSM state encoding
// BEHAVIOUR
//   Reset: State_out=IDLE(0), volume=0, amount=0, limitReached=0, txnDone=0.
//     Internal tick counter, latched price and latched preset cleared. All outputs registered.
//   States:
//     IDLE=0      txnStart -> ARMED. fuelEnable ignored.
//     ARMED=1     fuelEnable=1 -> DISPENSE. txnEnd -> DONE.
//     DISPENSE=2  fuelEnable=0 -> ARMED. txnEnd -> DONE.
//     DONE=3      txnStart -> ARMED. Otherwise hold totals.
//   Accepted txnStart (IDLE or DONE only) takes effect on the same edge:
//     volume, amount, tick counter, limitReached cleared; unitPrice and presetVol latched.
//     txnStart while in ARMED or DISPENSE is ignored.
//   Metering applies in ARMED or DISPENSE on every edge with fuelEnable=1 and limitReached=0:
//     tick increments.
//     When tick==TICKS_PER_UNIT-1: tick<=0, volume<=volume+1, amount<=amount+latched price.
//     Latency: the unit appears on volume/amount at the same edge as the final tick.
//     Partial ticks are retained across fuelEnable=0 gaps. Ticks are discarded on txnStart or reset.
//     The ARMED->DISPENSE transition edge counts as a tick if fuelEnable=1.
//   Limit:
//     Preset hit: latched preset!=0 and a volume increment makes volume==preset.
//     Saturation: volume==all-ones and one more unit would complete; that unit is dropped.
//     Either case: limitReached<=1 and state<=DONE on that edge.
//   Simultaneous events on one edge:
//     txnEnd with a unit completion: the unit is counted, then DONE.
//     txnEnd and limit: DONE, limitReached=1.
//     txnStart and txnEnd in DONE: txnStart wins.
//   DONE: no metering; volume, amount and limitReached hold until the next accepted txnStart.
//   Reset mid-operation: outputs go to reset values immediately (asynchronous), without waiting for a clock edge.
// TESTING
//   1. reset; txnStart with unitPrice=3, presetVol=0; fuelEnable=1 for 8 cycles
//      -> volume=2, amount=6, State_out=2.
//   2. price 3; fuelEnable 1 for 6 cycles, 0 for 3, 1 for 2
//      -> volume=2, amount=6; State_out 2->1->2.
//   3. price 5, preset 3; fuelEnable held 1
//      -> on 12th tick edge volume=3, amount=15, limitReached=1, State_out=3; extra cycles leave values unchanged.
//   4. price 2; txnEnd on the same edge as the 4th tick
//      -> volume=1, amount=2, txnDone=1, State_out=3.
//   5. Mid-DISPENSE (volume=1), assert reset between clock edges
//      -> all outputs 0 and State_out=0 before the next edge; fuelEnable afterwards in IDLE gives no count.
//   6. From DONE (volume=3), txnStart with price 7, preset 1; fuelEnable=1 for 4 cycles
//      -> volume=1, amount=7, limitReached=1, DONE; txnStart during ARMED/DISPENSE leaves totals untouched.

Source files
------------

// File: rtl/fuel_dispense_meter.sv
`default_nettype none
// ============================================================================
//  Module   : fuel_dispense_meter
//  Purpose  : Meters dispensed fuel volume in whole units, accumulates the
//             transaction amount (volume x latched unit price), raises a
//             sticky stop request on preset hit or volume saturation, and
//             runs the per-transaction IDLE/ARMED/DISPENSE/DONE state machine
//             read by the display/billing logic.
//  Revision : 1.0  initial release
// ============================================================================
module fuel_dispense_meter #(
   parameter int TICKS_PER_UNIT = 4,   // fuel-enabled cycles per volume unit (>=2)
   parameter int VOL_W          = 12,  // volume counter width
   parameter int PRICE_W        = 8,   // unit price width
   parameter int AMT_W          = 20   // amount width, >= VOL_W+PRICE_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fuelEnable,
   input  logic               txnStart,
   input  logic               txnEnd,
   input  logic [VOL_W-1:0]   presetVol,
   input  logic [PRICE_W-1:0] unitPrice,
   output logic [VOL_W-1:0]   volume,
   output logic [AMT_W-1:0]   amount,
   output logic               limitReached,
   output logic               txnDone,
   output logic [1:0]         State_out
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam int TICK_W = (TICKS_PER_UNIT > 2) ? $clog2(TICKS_PER_UNIT) : 1;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);
   localparam logic [VOL_W-1:0]  VOL_MAX   = {VOL_W{1'b1}};

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_ARMED    = 2'd1;
   localparam logic [1:0] ST_DISPENSE = 2'd2;
   localparam logic [1:0] ST_DONE     = 2'd3;

   // -------------------------------------------------------------------------
   // State registers and their next-state values
   // -------------------------------------------------------------------------
   logic [1:0]         state_q,  state_d;
   logic [TICK_W-1:0]  tick_q,   tick_d;
   logic [VOL_W-1:0]   volume_q, volume_d;
   logic [AMT_W-1:0]   amount_q, amount_d;
   logic               limit_q,  limit_d;
   logic               done_q,   done_d;
   logic [PRICE_W-1:0] price_q,  price_d;
   logic [VOL_W-1:0]   preset_q, preset_d;

   // Per-edge event decode
   logic               start_ok;     // txnStart accepted in the current state
   logic               active;       // ARMED or DISPENSE
   logic               meter;        // this edge counts a tick
   logic               unit_done;    // this tick completes a whole unit
   logic               saturate;     // completing unit would overflow volume
   logic               preset_hit;   // completed unit lands exactly on preset
   logic [VOL_W-1:0]   volume_inc;

   // Decode which metering events happen on the coming edge
   always_comb begin
      start_ok   = txnStart && ((state_q == ST_IDLE) || (state_q == ST_DONE));
      active     = (state_q == ST_ARMED) || (state_q == ST_DISPENSE);
      // limit_q is always 0 while active; gating on it keeps the stop
      // request authoritative even if that invariant were ever broken.
      meter      = active && fuelEnable && !limit_q;
      unit_done  = meter && (tick_q == TICK_LAST);
      saturate   = unit_done && (volume_q == VOL_MAX);
      volume_inc = volume_q + 1'b1;
      // Preset 0 means "no limit"; a saturating unit is dropped, so it can
      // never also count as a preset hit.
      preset_hit = unit_done && !saturate && (preset_q != '0)
                   && (volume_inc == preset_q);
   end

   // Next-state logic for the transaction FSM, meter and totals
   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      volume_d = volume_q;
      amount_d = amount_q;
      limit_d  = limit_q;
      price_d  = price_q;
      preset_d = preset_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // Totals hold in DONE until a new transaction is accepted;
            // fuel flow is ignored in both states.
            if (start_ok) begin
               state_d  = ST_ARMED;
               tick_d   = '0;
               volume_d = '0;
               amount_d = '0;
               limit_d  = 1'b0;
               price_d  = unitPrice;
               preset_d = presetVol;
            end
         end

         ST_ARMED, ST_DISPENSE: begin
            // Metering: partial ticks survive fuelEnable=0 gaps because
            // tick_q is only touched while fuel flows.
            if (meter) begin
               if (unit_done) begin
                  tick_d = '0;
                  if (!saturate) begin
                     volume_d = volume_inc;
                     amount_d = amount_q + AMT_W'(price_q);
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end

            // A limit outranks txnEnd only in that it also sets the sticky
            // flag; both end in DONE, and a unit completed on the txnEnd
            // edge has already been counted above.
            if (saturate || preset_hit) begin
               limit_d = 1'b1;
               state_d = ST_DONE;
            end else if (txnEnd) begin
               state_d = ST_DONE;
            end else if (fuelEnable) begin
               state_d = ST_DISPENSE;
            end else begin
               state_d = ST_ARMED;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      done_d = (state_d == ST_DONE);
   end

   // Register all state; asynchronous reset clears every output at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         tick_q   <= '0;
         volume_q <= '0;
         amount_q <= '0;
         limit_q  <= 1'b0;
         done_q   <= 1'b0;
         price_q  <= '0;
         preset_q <= '0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         volume_q <= volume_d;
         amount_q <= amount_d;
         limit_q  <= limit_d;
         done_q   <= done_d;
         price_q  <= price_d;
         preset_q <= preset_d;
      end
   end

   // Outputs come straight from flops
   assign volume       = volume_q;
   assign amount       = amount_q;
   assign limitReached = limit_q;
   assign txnDone      = done_q;
   assign State_out    = state_q;

endmodule
`default_nettype wire
